// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the framebuffer producer and the arbiter.
// clk/rst are carried so a slave can use the same nets as the master.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  ack, dat_sm,
        output adr, dat_ms, we, sel, stb, cyc, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
        output ack, dat_sm
    );
endinterface

// File: rtl/fb_pattern_writer.sv
// Framebuffer test-pattern producer. Writes one 32-bit pixel per acked
// Wishbone cycle, walking the frame in raster order, and drops cyc for a
// fixed number of cycles after every BURST writes so the video reader can
// win the arbiter regularly.
module fb_pattern_writer #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64,
    parameter int GAP   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    wshb_if.master        wshb_ifm,
    output logic          frame_done,
    output logic [7:0]    frame_cnt
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int GW = (GAP   > 1) ? $clog2(GAP)   : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [XW-1:0]   x_r;
    logic [YW-1:0]   y_r;
    logic [7:0]      frame_cnt_r;
    logic [BW-1:0]   burst_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            frame_done_r;

    logic            ack_take_s;
    logic            x_last_s;
    logic            y_last_s;
    logic            burst_last_s;
    logic            gap_last_s;
    logic            cyc_s;
    logic [31:0]     pix_idx_s;
    logic [31:0]     pix_dat_s;

    // Grid lines every 16 pixels in white; elsewhere a colour ramp whose
    // blue channel follows the frame counter so successive frames differ.
    function automatic logic [31:0] pattern_pixel(
        input logic [3:0] x_lo,
        input logic [3:0] y_lo,
        input logic [7:0] red,
        input logic [7:0] green,
        input logic [7:0] blue
    );
        logic [31:0] pix;
        if ((x_lo == 4'd0) || (y_lo == 4'd0)) begin
            pix = 32'h00FF_FFFF;
        end else begin
            pix = {8'h00, red, green, blue};
        end
        return pix;
    endfunction

    // An ack only counts while this master owns the bus.
    assign ack_take_s   = (state_r == ST_BURST) && wshb_ifm.ack;
    assign x_last_s     = (x_r == XW'(HDISP - 1));
    assign y_last_s     = (y_r == YW'(VDISP - 1));
    assign burst_last_s = (burst_cnt_r == BW'(BURST - 1));
    assign gap_last_s   = (gap_cnt_r == GW'(GAP - 1));

    // Byte address and pixel value follow the counters directly, so they
    // move on exactly the edge that samples an ack and hold otherwise.
    assign pix_idx_s = 32'(x_r) + (32'(y_r) * 32'(HDISP));
    assign pix_dat_s = pattern_pixel(4'(x_r), 4'(y_r), 8'(x_r), 8'(y_r), frame_cnt_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; en is only looked at on tenure boundaries.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (ack_take_s && burst_last_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            ST_RELEASE: begin
                if (gap_last_s) begin
                    state_nxt_s = en ? ST_BURST : ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus request decode: cyc and stb are asserted only while bursting.
    always_comb begin
        cyc_s = 1'b0;
        case (state_r)
            ST_IDLE:    cyc_s = 1'b0;
            ST_BURST:   cyc_s = 1'b1;
            ST_RELEASE: cyc_s = 1'b0;
            default:    cyc_s = 1'b0;
        endcase
    end

    // Raster position, frame counter and end-of-frame pulse advance per ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r          <= '0;
            y_r          <= '0;
            frame_cnt_r  <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (ack_take_s) begin
                if (x_last_s) begin
                    x_r <= '0;
                    if (y_last_s) begin
                        y_r          <= '0;
                        frame_cnt_r  <= frame_cnt_r + 8'd1;
                        frame_done_r <= 1'b1;
                    end else begin
                        y_r <= y_r + YW'(1);
                    end
                end else begin
                    x_r <= x_r + XW'(1);
                end
            end else begin
                x_r <= x_r;
            end
        end
    end

    // Writes completed in the current tenure.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_r <= '0;
        end else if (ack_take_s) begin
            if (burst_last_s) begin
                burst_cnt_r <= '0;
            end else begin
                burst_cnt_r <= burst_cnt_r + BW'(1);
            end
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Idle cycles spent with the bus released between tenures.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_r <= '0;
        end else if (state_r == ST_RELEASE) begin
            if (gap_last_s) begin
                gap_cnt_r <= '0;
            end else begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end
        end else begin
            gap_cnt_r <= '0;
        end
    end

    assign wshb_ifm.cyc    = cyc_s;
    assign wshb_ifm.stb    = cyc_s;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = pix_idx_s << 2;
    assign wshb_ifm.dat_ms = pix_dat_s;

    assign frame_done = frame_done_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench: dut_a uses the full 800x480 geometry for the single-pixel
// address/data vector, dut_b a 32x4 frame so wraps are reached quickly.
module tb_fb_pattern_writer;

    localparam int HB        = 32;
    localparam int VB        = 4;
    localparam int FRAME_PIX = HB * VB;

    logic clk = 1'b0;
    logic rst;
    logic en_a, en_b;
    logic ack_a, ack_b;
    logic       frame_done_a, frame_done_b;
    logic [7:0] frame_cnt_a, frame_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;
    int m_idx;
    int m_p;

    always #5 clk = ~clk;

    wshb_if wb_a (.clk(clk), .rst(rst));
    wshb_if wb_b (.clk(clk), .rst(rst));

    assign wb_a.ack    = ack_a;
    assign wb_a.dat_sm = 32'h0;
    assign wb_b.ack    = ack_b;
    assign wb_b.dat_sm = 32'h0;

    fb_pattern_writer #(.HDISP(800), .VDISP(480), .BURST(8), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .wshb_ifm(wb_a),
        .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
    );

    fb_pattern_writer #(.HDISP(HB), .VDISP(VB), .BURST(8), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .wshb_ifm(wb_b),
        .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
    );

    // Expected pixel for the idx-th write of dut_b since reset.
    function automatic logic [31:0] exp_pix(input int idx);
        int px, py, pf;
        logic [31:0] v;
        px = idx % HB;
        py = (idx / HB) % VB;
        pf = (idx / FRAME_PIX) % 256;
        if ((px % 16 == 0) || (py % 16 == 0)) v = 32'h00FFFFFF;
        else v = {8'h00, 8'(px), 8'(py), 8'(pf)};
        return v;
    endfunction

    function automatic logic [31:0] exp_adr(input int idx);
        return 32'((idx % FRAME_PIX) * 4);
    endfunction

    task automatic test_reset();
        rst = 1'b1; en_b = 1'b1; en_a = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++; if (wb_b.cyc !== 1'b0 || wb_b.stb !== 1'b0) $display("FAIL reset_cyc: cyc=%b stb=%b want 0/0", wb_b.cyc, wb_b.stb); else n_pass++;
        end
        n_checks++; if (wb_b.adr !== 32'h0) $display("FAIL reset_adr: got %h want 0", wb_b.adr); else n_pass++;
        n_checks++; if (wb_b.dat_ms !== 32'h00FFFFFF) $display("FAIL reset_dat: got %h want 00ffffff", wb_b.dat_ms); else n_pass++;
        n_checks++; if (frame_cnt_b !== 8'd0 || frame_done_b !== 1'b0) $display("FAIL reset_frame: cnt=%0d done=%b want 0/0", frame_cnt_b, frame_done_b); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (wb_b.cyc !== 1'b1 || wb_b.stb !== 1'b1) $display("FAIL start_cyc: cyc=%b stb=%b want 1/1", wb_b.cyc, wb_b.stb); else n_pass++;
        n_checks++; if (wb_b.adr !== 32'h0) $display("FAIL start_adr: got %h want 0", wb_b.adr); else n_pass++;
        n_checks++; if (wb_b.dat_ms !== 32'h00FFFFFF) $display("FAIL start_dat: got %h want 00ffffff", wb_b.dat_ms); else n_pass++;
        n_checks++; if (wb_b.we !== 1'b1 || wb_b.sel !== 4'hF || wb_b.cti !== 3'd0 || wb_b.bte !== 2'd0) $display("FAIL const_outs: we=%b sel=%h cti=%0d bte=%0d want 1/f/0/0", wb_b.we, wb_b.sel, wb_b.cti, wb_b.bte); else n_pass++;
        n_checks++; if (wb_a.cyc !== 1'b0) $display("FAIL idle_no_en: cyc=%b want 0", wb_a.cyc); else n_pass++;
        m_idx = 0; m_p = 0;
    endtask

    task automatic test_burst_gap();
        bit ec;
        for (int i = 0; i < 30; i++) begin
            ec = (m_p < 8);
            n_checks++; if (wb_b.cyc !== ec || wb_b.stb !== ec) $display("FAIL burst_cyc: cycle %0d cyc=%b stb=%b want %b", i, wb_b.cyc, wb_b.stb, ec); else n_pass++;
            if (ec) begin
                n_checks++; if (wb_b.adr !== exp_adr(m_idx)) $display("FAIL burst_adr: got %h want %h", wb_b.adr, exp_adr(m_idx)); else n_pass++;
                n_checks++; if (wb_b.dat_ms !== exp_pix(m_idx)) $display("FAIL burst_dat: got %h want %h", wb_b.dat_ms, exp_pix(m_idx)); else n_pass++;
            end
            ack_b = 1'b1;
            @(posedge clk); #1;
            if (ec) m_idx++;
            m_p = (m_p + 1) % 10;
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 24; i++) begin
            n_checks++; if (wb_b.cyc !== 1'b1) $display("FAIL wait_cyc: step %0d cyc=%b want 1", i, wb_b.cyc); else n_pass++;
            n_checks++; if (wb_b.adr !== exp_adr(m_idx) || wb_b.dat_ms !== exp_pix(m_idx)) $display("FAIL wait_hold: adr=%h dat=%h want %h %h", wb_b.adr, wb_b.dat_ms, exp_adr(m_idx), exp_pix(m_idx)); else n_pass++;
            ack_b = (i % 3 == 2);
            @(posedge clk); #1;
            if (ack_b) m_idx++;
        end
        for (int g = 0; g < 2; g++) begin
            n_checks++; if (wb_b.cyc !== 1'b0) $display("FAIL wait_gap_cyc: gap %0d cyc=%b want 0", g, wb_b.cyc); else n_pass++;
            n_checks++; if (wb_b.adr !== exp_adr(m_idx)) $display("FAIL gap_ack_ignored: adr=%h want %h", wb_b.adr, exp_adr(m_idx)); else n_pass++;
            ack_b = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (wb_b.cyc !== 1'b1 || wb_b.adr !== 32'h00000080) $display("FAIL wait_resume: cyc=%b adr=%h want 1 00000080", wb_b.cyc, wb_b.adr); else n_pass++;
        m_p = 0;
    endtask

    task automatic test_frame_wrap();
        bit ec;
        bit fd_exp;
        int pulses;
        fd_exp = 1'b0; pulses = 0;
        for (int i = 0; i < 170; i++) begin
            ec = (m_p < 8);
            n_checks++; if (wb_b.cyc !== ec) $display("FAIL wrap_cyc: cycle %0d cyc=%b want %b", i, wb_b.cyc, ec); else n_pass++;
            n_checks++; if (frame_done_b !== fd_exp) $display("FAIL wrap_done: cycle %0d done=%b want %b", i, frame_done_b, fd_exp); else n_pass++;
            n_checks++; if (frame_cnt_b !== 8'((m_idx / FRAME_PIX) % 256)) $display("FAIL wrap_cnt: got %0d want %0d", frame_cnt_b, (m_idx / FRAME_PIX) % 256); else n_pass++;
            if (frame_done_b === 1'b1) pulses++;
            if (ec) begin
                n_checks++; if (wb_b.adr !== exp_adr(m_idx) || wb_b.dat_ms !== exp_pix(m_idx)) $display("FAIL wrap_pix: idx %0d adr=%h dat=%h want %h %h", m_idx, wb_b.adr, wb_b.dat_ms, exp_adr(m_idx), exp_pix(m_idx)); else n_pass++;
                if (m_idx == FRAME_PIX) begin
                    n_checks++; if (wb_b.adr !== 32'h0) $display("FAIL wrap_adr0: got %h want 0", wb_b.adr); else n_pass++;
                end
                if (m_idx == FRAME_PIX + 33) begin
                    n_checks++; if (wb_b.dat_ms !== 32'h00010101) $display("FAIL wrap_pix11: got %h want 00010101", wb_b.dat_ms); else n_pass++;
                end
            end
            ack_b = 1'b1;
            @(posedge clk); #1;
            fd_exp = 1'b0;
            if (ec) begin
                m_idx++;
                if (m_idx % FRAME_PIX == 0) fd_exp = 1'b1;
            end
            m_p = (m_p + 1) % 10;
        end
        n_checks++; if (pulses != 1) $display("FAIL wrap_pulses: got %0d want 1", pulses); else n_pass++;
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (wb_b.cyc !== 1'b1 || wb_b.adr !== exp_adr(m_idx)) $display("FAIL endrop_burst: ack %0d cyc=%b adr=%h want 1 %h", i, wb_b.cyc, wb_b.adr, exp_adr(m_idx)); else n_pass++;
            ack_b = 1'b1;
            if (i == 2) en_b = 1'b0;
            @(posedge clk); #1;
            m_idx++;
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (wb_b.cyc !== 1'b0 || wb_b.adr !== exp_adr(m_idx)) $display("FAIL endrop_idle: cycle %0d cyc=%b adr=%h want 0 %h", i, wb_b.cyc, wb_b.adr, exp_adr(m_idx)); else n_pass++;
            ack_b = 1'b1;
            @(posedge clk); #1;
        end
        en_b = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wb_b.cyc !== 1'b1 || wb_b.adr !== 32'h000000C0) $display("FAIL endrop_restart: cyc=%b adr=%h want 1 000000c0", wb_b.cyc, wb_b.adr); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            ack_b = 1'b1;
            @(posedge clk); #1;
            m_idx++;
        end
        n_checks++; if (wb_b.cyc !== 1'b1 || frame_cnt_b !== 8'd1) $display("FAIL prerst_state: cyc=%b cnt=%0d want 1 1", wb_b.cyc, frame_cnt_b); else n_pass++;
        rst = 1'b1; ack_b = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wb_b.cyc !== 1'b0 || wb_b.stb !== 1'b0) $display("FAIL rst_cyc: cyc=%b stb=%b want 0/0", wb_b.cyc, wb_b.stb); else n_pass++;
        n_checks++; if (wb_b.adr !== 32'h0 || wb_b.dat_ms !== 32'h00FFFFFF) $display("FAIL rst_pix: adr=%h dat=%h want 0 00ffffff", wb_b.adr, wb_b.dat_ms); else n_pass++;
        n_checks++; if (frame_cnt_b !== 8'd0 || frame_done_b !== 1'b0) $display("FAIL rst_frame: cnt=%0d done=%b want 0/0", frame_cnt_b, frame_done_b); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        m_idx = 0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (wb_b.cyc !== 1'b1 || wb_b.adr !== exp_adr(m_idx)) $display("FAIL rst_restart: ack %0d cyc=%b adr=%h want 1 %h", i, wb_b.cyc, wb_b.adr, exp_adr(m_idx)); else n_pass++;
            ack_b = 1'b1;
            @(posedge clk); #1;
            m_idx++;
        end
        n_checks++; if (wb_b.cyc !== 1'b0) $display("FAIL rst_burst_len: cyc=%b want 0", wb_b.cyc); else n_pass++;
    endtask

    task automatic test_frame_cnt_wrap();
        int budget;
        budget = 0;
        while (m_idx < 256 * FRAME_PIX && budget < 60000) begin
            ack_b = wb_b.cyc;
            @(posedge clk); #1;
            budget++;
            if (ack_b) begin
                m_idx++;
                if (m_idx == 255 * FRAME_PIX) begin
                    n_checks++; if (frame_cnt_b !== 8'd255 || frame_done_b !== 1'b1) $display("FAIL cnt_255: cnt=%0d done=%b want 255 1", frame_cnt_b, frame_done_b); else n_pass++;
                end
            end
        end
        ack_b = 1'b0;
        n_checks++; if (m_idx != 256 * FRAME_PIX) $display("FAIL cnt_wrap_timeout: acks=%0d want %0d", m_idx, 256 * FRAME_PIX); else n_pass++;
        n_checks++; if (frame_cnt_b !== 8'd0 || frame_done_b !== 1'b1) $display("FAIL cnt_wrap: cnt=%0d done=%b want 0 1", frame_cnt_b, frame_done_b); else n_pass++;
    endtask

    task automatic test_pixel_addr();
        int a_idx;
        int budget;
        bit found;
        a_idx = 0; budget = 0; found = 1'b0;
        en_a = 1'b1;
        while (a_idx <= 2417 && budget < 5000) begin
            if (wb_a.cyc === 1'b1 && a_idx == 2416) begin
                n_checks++; if (wb_a.dat_ms !== 32'h00FFFFFF) $display("FAIL pix_16_3: got %h want 00ffffff", wb_a.dat_ms); else n_pass++;
            end
            if (wb_a.cyc === 1'b1 && a_idx == 2417) begin
                found = 1'b1;
                n_checks++; if (wb_a.adr !== 32'h000025C4) $display("FAIL pix_17_3_adr: got %h want 000025c4", wb_a.adr); else n_pass++;
                n_checks++; if (wb_a.dat_ms !== 32'h00110300) $display("FAIL pix_17_3_dat: got %h want 00110300", wb_a.dat_ms); else n_pass++;
            end
            ack_a = wb_a.cyc;
            @(posedge clk); #1;
            budget++;
            if (ack_a) a_idx++;
        end
        ack_a = 1'b0;
        n_checks++; if (!found) $display("FAIL pix_17_3_reached: acks=%0d want 2418", a_idx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_burst_gap();
        test_wait_states();
        test_frame_wrap();
        test_en_drop();
        test_reset_mid_burst();
        test_frame_cnt_wrap();
        test_pixel_addr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
